// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-port memory-bus arbiter.
package mem_bus_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    // One latched bus command; field widths follow the default bus widths.
    typedef struct packed {
        logic                      write;
        logic [DEFAULT_ADDR_W-1:0] addr;
        logic [DEFAULT_DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester handshakes plus the mmio access port.
// The arbiter uses the slave view; requesters and the memory use the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              req0_rvalid;
    logic [DATA_W-1:0] req0_rdata;

    logic              req1_valid;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              req1_rvalid;
    logic [DATA_W-1:0] req1_rdata;

    logic              memread;
    logic              memwrite;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;

    logic              busy;
    logic              owner;

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_ready, req0_rvalid, req0_rdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_ready, req1_rvalid, req1_rdata,
        output memread, memwrite, mem_addr, mem_writedata,
        input  mem_readdata,
        output busy, owner
    );

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_ready, req0_rvalid, req0_rdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_ready, req1_rvalid, req1_rdata,
        input  memread, memwrite, mem_addr, mem_writedata,
        output mem_readdata,
        input  busy, owner
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin picker: on a tie the requester that
// did not win last time gets the grant.
module rr_arbiter2 (
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_owner,
    output logic o_gnt_valid,
    output logic o_gnt_idx
);

    // Pick the lone valid requester, or the non-owner when both are valid.
    always_comb begin
        o_gnt_valid = i_valid0 | i_valid1;
        o_gnt_idx   = 1'b0;
        if (i_valid0 && i_valid1) begin
            o_gnt_idx = ~i_owner;
        end else if (i_valid1) begin
            o_gnt_idx = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one mmio access port between two requesters, one transaction at a
// time, with round-robin choice and a fixed read latency back to the owner.
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int READ_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    mem_arbiter_if.slave    bus
);

    localparam int CNT_W = $clog2(READ_LAT + 1);

    arb_state_t       r_state;
    mem_cmd_t         r_cmd;
    logic             r_owner;
    logic             r_memread;
    logic             r_memwrite;
    logic [1:0]       r_rvalid;
    logic [CNT_W-1:0] r_cnt;

    logic             w_gnt_valid;
    logic             w_gnt_idx;
    logic             w_accept;
    mem_cmd_t         w_sel_cmd;

    rr_arbiter2 u_rr (
        .i_valid0    (bus.req0_valid),
        .i_valid1    (bus.req1_valid),
        .i_owner     (r_owner),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_idx   (w_gnt_idx)
    );

    assign w_accept       = (r_state == IDLE) && w_gnt_valid;
    assign bus.req0_ready = w_accept && !w_gnt_idx;
    assign bus.req1_ready = w_accept && w_gnt_idx;

    // Route the winning requester's command towards the command register.
    always_comb begin
        w_sel_cmd = '0;
        if (w_gnt_idx) begin
            w_sel_cmd.write = bus.req1_write;
            w_sel_cmd.addr  = bus.req1_addr;
            w_sel_cmd.wdata = bus.req1_wdata;
        end else begin
            w_sel_cmd.write = bus.req0_write;
            w_sel_cmd.addr  = bus.req0_addr;
            w_sel_cmd.wdata = bus.req0_wdata;
        end
    end

    // Transaction FSM; strobes and rvalid are one-cycle registered pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cmd      <= '0;
            r_owner    <= 1'b1;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_rvalid   <= 2'b00;
            r_cnt      <= '0;
        end else begin
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_rvalid   <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cmd      <= w_sel_cmd;
                        r_owner    <= w_gnt_idx;
                        r_memwrite <= w_sel_cmd.write;
                        r_memread  <= !w_sel_cmd.write;
                        r_state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_cmd.write) begin
                        r_state <= IDLE;
                    end else if (READ_LAT == 1) begin
                        r_state           <= RESP;
                        r_rvalid[r_owner] <= 1'b1;
                    end else begin
                        r_state <= WAIT;
                        r_cnt   <= CNT_W'(READ_LAT - 1);
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state           <= RESP;
                        r_rvalid[r_owner] <= 1'b1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.memread       = r_memread;
    assign bus.memwrite      = r_memwrite;
    assign bus.mem_addr      = r_cmd.addr;
    assign bus.mem_writedata = r_cmd.wdata;
    assign bus.req0_rvalid   = r_rvalid[0];
    assign bus.req1_rvalid   = r_rvalid[1];
    assign bus.req0_rdata    = r_rvalid[0] ? bus.mem_readdata : '0;
    assign bus.req1_rdata    = r_rvalid[1] ? bus.mem_readdata : '0;
    assign bus.busy          = (r_state != IDLE);
    assign bus.owner         = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with READ_LAT=3 and hand-computed expectations.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   compareCount  = 0;
    int   mismatchCount = 0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) busIf ();

    mem_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .READ_LAT (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busIf)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one requester's handshake inputs.
    task automatic applyStimulus(input int port, input logic valid, input logic write,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            busIf.req0_valid = valid;
            busIf.req0_write = write;
            busIf.req0_addr  = addr;
            busIf.req0_wdata = wdata;
        end else begin
            busIf.req1_valid = valid;
            busIf.req1_write = write;
            busIf.req1_addr  = addr;
            busIf.req1_wdata = wdata;
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        busIf.mem_readdata = 32'h0;

        // Reset values
        nextCycle();
        #1;
        checkOutput("rst_memread",  32'(busIf.memread), 32'd0);
        checkOutput("rst_memwrite", 32'(busIf.memwrite), 32'd0);
        checkOutput("rst_ready0",   32'(busIf.req0_ready), 32'd0);
        checkOutput("rst_ready1",   32'(busIf.req1_ready), 32'd0);
        checkOutput("rst_busy",     32'(busIf.busy), 32'd0);
        checkOutput("rst_owner",    32'(busIf.owner), 32'd1);
        checkOutput("rst_addr",     busIf.mem_addr, 32'h0);
        checkOutput("rst_wdata",    busIf.mem_writedata, 32'h0);
        nextCycle();
        reset = 1'b1;
        nextCycle();

        // Single write from requester 0
        applyStimulus(0, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        #1;
        checkOutput("wr_ready0", 32'(busIf.req0_ready), 32'd1);
        checkOutput("wr_ready1", 32'(busIf.req1_ready), 32'd0);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("wr_memwrite", 32'(busIf.memwrite), 32'd1);
        checkOutput("wr_memread",  32'(busIf.memread), 32'd0);
        checkOutput("wr_addr",     busIf.mem_addr, 32'h0000_0010);
        checkOutput("wr_data",     busIf.mem_writedata, 32'hDEAD_BEEF);
        checkOutput("wr_busy",     32'(busIf.busy), 32'd1);
        checkOutput("wr_owner",    32'(busIf.owner), 32'd0);
        nextCycle();
        checkOutput("wr_memwrite_off", 32'(busIf.memwrite), 32'd0);
        checkOutput("wr_idle",         32'(busIf.busy), 32'd0);

        // Single read from requester 1, data valid at T+4
        busIf.mem_readdata = 32'h1234_5678;
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
        #1;
        checkOutput("rd_ready1", 32'(busIf.req1_ready), 32'd1);
        nextCycle();
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("rd_memread", 32'(busIf.memread), 32'd1);
        checkOutput("rd_addr",    busIf.mem_addr, 32'h0000_0020);
        for (int t = 2; t <= 3; t++) begin
            nextCycle();
            checkOutput($sformatf("rd_memread_off_t%0d", t), 32'(busIf.memread), 32'd0);
            checkOutput($sformatf("rd_rvalid1_t%0d", t), 32'(busIf.req1_rvalid), 32'd0);
        end
        nextCycle();
        checkOutput("rd_rvalid1", 32'(busIf.req1_rvalid), 32'd1);
        checkOutput("rd_rdata1",  busIf.req1_rdata, 32'h1234_5678);
        checkOutput("rd_rvalid0", 32'(busIf.req0_rvalid), 32'd0);
        nextCycle();
        checkOutput("rd_rvalid1_off", 32'(busIf.req1_rvalid), 32'd0);
        checkOutput("rd_idle",        32'(busIf.busy), 32'd0);

        // Tie fairness: both hold valid, accepts at 0,2,4,6 in order 0,1,0,1
        applyStimulus(0, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_00A0);
        applyStimulus(1, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_00B1);
        for (int c = 0; c <= 7; c++) begin
            if (c == 7) begin
                applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
                applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            #1;
            checkOutput($sformatf("tie_ready0_c%0d", c), 32'(busIf.req0_ready), 32'((c == 0) || (c == 4)));
            checkOutput($sformatf("tie_ready1_c%0d", c), 32'(busIf.req1_ready), 32'((c == 2) || (c == 6)));
            if (c % 2 == 1) begin
                checkOutput($sformatf("tie_owner_c%0d", c), 32'(busIf.owner), 32'((c == 3) || (c == 7)));
                checkOutput($sformatf("tie_addr_c%0d", c), busIf.mem_addr,
                            ((c == 1) || (c == 5)) ? 32'h0000_0100 : 32'h0000_0200);
                checkOutput($sformatf("tie_memwrite_c%0d", c), 32'(busIf.memwrite), 32'd1);
            end
            nextCycle();
        end

        // Busy rejection: requester 0 re-requests during its own read
        busIf.mem_readdata = 32'hCAFE_0001;
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        #1;
        checkOutput("busy_ready0_T", 32'(busIf.req0_ready), 32'd1);
        nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0044, 32'h0);
        for (int t = 1; t <= 4; t++) begin
            #1;
            checkOutput($sformatf("busy_ready0_t%0d", t), 32'(busIf.req0_ready), 32'd0);
            checkOutput($sformatf("busy_addr_t%0d", t), busIf.mem_addr, 32'h0000_0040);
            if (t == 4) begin
                checkOutput("busy_rvalid0", 32'(busIf.req0_rvalid), 32'd1);
                checkOutput("busy_rdata0",  busIf.req0_rdata, 32'hCAFE_0001);
            end
            nextCycle();
        end
        #1;
        checkOutput("busy_ready0_idle", 32'(busIf.req0_ready), 32'd1);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("busy_new_addr",    busIf.mem_addr, 32'h0000_0044);
        checkOutput("busy_new_memread", 32'(busIf.memread), 32'd1);
        for (int t = 0; t < 4; t++) nextCycle();
        checkOutput("busy_drained", 32'(busIf.busy), 32'd0);

        // Valid withdrawn: requester 1 pulses valid while busy
        applyStimulus(0, 1'b1, 1'b1, 32'h0000_0050, 32'h0000_0055);
        #1;
        checkOutput("wd_ready0", 32'(busIf.req0_ready), 32'd1);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0060, 32'h0);
        #1;
        checkOutput("wd_ready1_busy", 32'(busIf.req1_ready), 32'd0);
        checkOutput("wd_memwrite",    32'(busIf.memwrite), 32'd1);
        checkOutput("wd_memread",     32'(busIf.memread), 32'd0);
        nextCycle();
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int t = 2; t <= 4; t++) begin
            #1;
            checkOutput($sformatf("wd_ready1_t%0d", t), 32'(busIf.req1_ready), 32'd0);
            checkOutput($sformatf("wd_memread_t%0d", t), 32'(busIf.memread), 32'd0);
            checkOutput($sformatf("wd_memwrite_t%0d", t), 32'(busIf.memwrite), 32'd0);
            checkOutput($sformatf("wd_busy_t%0d", t), 32'(busIf.busy), 32'd0);
            checkOutput($sformatf("wd_addr_t%0d", t), busIf.mem_addr, 32'h0000_0050);
            nextCycle();
        end

        // Reset asserted while a read sits in WAIT
        busIf.mem_readdata = 32'h0000_0077;
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0070, 32'h0);
        #1;
        checkOutput("mr_ready1", 32'(busIf.req1_ready), 32'd1);
        nextCycle();
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("mr_memread", 32'(busIf.memread), 32'd1);
        nextCycle();
        checkOutput("mr_in_wait", 32'(busIf.busy), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("mr_busy",     32'(busIf.busy), 32'd0);
        checkOutput("mr_memread",  32'(busIf.memread), 32'd0);
        checkOutput("mr_memwrite", 32'(busIf.memwrite), 32'd0);
        checkOutput("mr_addr",     busIf.mem_addr, 32'h0);
        checkOutput("mr_wdata",    busIf.mem_writedata, 32'h0);
        checkOutput("mr_owner",    32'(busIf.owner), 32'd1);
        checkOutput("mr_rdata1",   busIf.req1_rdata, 32'h0);
        for (int t = 0; t < 3; t++) begin
            nextCycle();
            checkOutput($sformatf("mr_rvalid1_t%0d", t), 32'(busIf.req1_rvalid), 32'd0);
            checkOutput($sformatf("mr_rvalid0_t%0d", t), 32'(busIf.req0_rvalid), 32'd0);
        end
        reset = 1'b1;
        nextCycle();
        checkOutput("mr_rvalid1_after", 32'(busIf.req1_rvalid), 32'd0);
        applyStimulus(0, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_0088);
        applyStimulus(1, 1'b1, 1'b1, 32'h0000_0090, 32'h0000_0099);
        #1;
        checkOutput("mr_tie_ready0", 32'(busIf.req0_ready), 32'd1);
        checkOutput("mr_tie_ready1", 32'(busIf.req1_ready), 32'd0);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("mr_tie_addr",  busIf.mem_addr, 32'h0000_0080);
        checkOutput("mr_tie_owner", 32'(busIf.owner), 32'd0);
        nextCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory-bus arbiter that shares the single `mmio` access port (`memread`/`memwrite`/`mem_addr`/`mem_writedata`/`mem_readdata`) between the `cpu` and a second bus master such as a debug loader or DMA engine. It accepts one transaction at a time from either requester over a valid/ready handshake, picks between them round-robin, and issues a one-cycle command to `mmio`. It returns read data to the owning requester after a fixed, parameterised read latency.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `READ_LAT`, 1, cycles from the `memread` cycle to the cycle `mem_readdata` is valid; legal values are ≥1.

- `clk`  in  1  system clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `reqN_valid`  in  1  requester N (N=0,1) has a transaction pending.
- `reqN_write`  in  1  1 = write, 0 = read.
- `reqN_addr`  in  ADDR_W  transaction address.
- `reqN_wdata`  in  DATA_W  write data.
- `reqN_ready`  out  1  transaction accepted this cycle.
- `reqN_rvalid`  out  1  one-cycle pulse: read data for requester N is valid.
- `reqN_rdata`  out  DATA_W  read data, meaningful only while `reqN_rvalid`=1.
- `memread`  out  1  read strobe to `mmio`.
- `memwrite`  out  1  write strobe to `mmio`.
- `mem_addr`  out  ADDR_W  address to `mmio`.
- `mem_writedata`  out  DATA_W  write data to `mmio`.
- `mem_readdata`  in  DATA_W  read data from `mmio`.
- `busy`  out  1  high in every state except IDLE.
- `owner`  out  1  index of the most recently accepted requester.

## Operation
- **Handshake**
  - A requester holds valid/write/addr/wdata stable until it sees ready.
  - Accept means `valid & ready` in the same cycle.
  - A requester may drop valid before acceptance; nothing happens.
- **States:** IDLE, ACCESS, WAIT, RESP.
- **IDLE**
  - `reqN_ready` is combinational: state==IDLE and N is the winner.
  - Winner when only one requester is valid: that requester.
  - Winner when both are valid: the requester other than `owner`.
  - On accept: latch write/addr/wdata into the command registers, set `owner`=N, and go to ACCESS.
- **ACCESS**
  - Exactly one cycle.
  - Asserts `memwrite` (write) or `memread` (read).
  - Write: next state is IDLE.
  - Read: next state is RESP if READ_LAT==1, otherwise WAIT with the counter loaded to READ_LAT-1.
- **WAIT**
  - Decrement the counter each cycle.
  - Move to RESP when the counter reaches 1.
- **RESP**
  - `reqN_rvalid`=1 for `owner` only.
  - `reqN_rdata` is `mem_readdata` passed through combinationally.
  - Next state is IDLE.
- **Outside accesses:** `mem_addr` and `mem_writedata` hold their last latched values and change only on accept.
- **No acceptance while busy:** both ready outputs stay 0 outside IDLE, including for the owner's own next request.
- **Reset:** all state clears immediately, whatever the state. An in-flight transaction is dropped and produces no rvalid and no strobe.
- **Reset values:**
  - state IDLE.
  - `memread`, `memwrite`, both ready, both rvalid, `busy`: all 0.
  - `mem_addr`, `mem_writedata`, both rdata: all 0.
  - `owner`=1, so requester 0 wins the first tie.

## Timing
- Accept occurs in cycle T.
- Strobe (`memread` or `memwrite`) is high in cycle T+1 only.
- Write: back in IDLE at T+2, so the next accept can happen at T+2 (2 cycles per write).
- Read: rvalid in cycle T+1+READ_LAT; IDLE at T+2+READ_LAT (2+READ_LAT cycles per read).
- The strobe and all `mem_*` outputs are registered. Ready and rdata are the only combinational outputs.
- `memread` and `memwrite` are never high in the same cycle.

## Structure
- Package `mem_bus_pkg`:
  - state enum `arb_state_t` {IDLE, ACCESS, WAIT, RESP};
  - default `ADDR_W`/`DATA_W` constants;
  - packed struct `mem_cmd_t` {write, addr, wdata}, used for the latched command.
- Sub-module `rr_arbiter2`:
  - combinational two-way round-robin picker;
  - inputs: two valids and `owner`;
  - outputs: grant valid and grant index.
- The counter width is `$clog2(READ_LAT+1)`.

## Test plan
- **Reset:** assert `reset`=0 mid-read (in WAIT) → all outputs return to their reset values immediately, no rvalid ever pulses, and requester 0 wins the first tie after release.
- **Single write:** req0 writes addr 0x0000_0010, data 0xDEAD_BEEF → ready0 at T, `memwrite`=1 with those values at T+1, `busy`=0 at T+2.
- **Single read, READ_LAT=3:** req1 reads 0x20 and the model returns 0x1234_5678 → `memread` at T+1, rvalid1=1 with rdata1=0x1234_5678 at T+4, rvalid0 stays 0.
- **Tie fairness:** both requesters hold valid continuously for 4 writes → accept order is 0,1,0,1, accepts fall at T, T+2, T+4, T+6, and `owner` toggles on each accept.
- **Busy rejection:** req0 re-asserts valid during its own ACCESS/WAIT/RESP → ready0 stays 0 until IDLE, and `mem_addr` is unchanged until the new accept.
- **Valid withdrawn:** req1 pulses valid for one cycle while the arbiter is busy, then drops it → no accept and no strobe for req1.
